// File: rtl/imm_extend_unit.sv
// Immediate extension unit: extends a raw immediate per mode at push time and
// queues the OUT_W-bit results in a 2-entry FIFO with valid/ready handshakes.
module imm_extend_unit #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [15:0]      out_count
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [1:0]       count_reg;
  logic [OUT_W-1:0] head_reg;
  logic [OUT_W-1:0] tail_reg;
  logic [15:0]      out_count_reg;
  logic [OUT_W-1:0] sext_value;
  logic [OUT_W-1:0] zext_value;
  logic [OUT_W-1:0] upper_value;
  logic [OUT_W-1:0] branch_value;
  logic [OUT_W-1:0] ext_value;
  logic             push;
  logic             pop;

  assign sext_value   = {{PAD_W{in_data[IN_W-1]}}, in_data};
  assign zext_value   = {{PAD_W{1'b0}}, in_data};
  assign upper_value  = {in_data, {PAD_W{1'b0}}};
  assign branch_value = sext_value << BR_SHIFT;

  always_comb begin
    ext_value = sext_value;
    case (in_mode)
      2'b00:   ext_value = sext_value;
      2'b01:   ext_value = zext_value;
      2'b10:   ext_value = upper_value;
      2'b11:   ext_value = branch_value;
      default: ext_value = sext_value;
    endcase
  end

  // Handshake readiness comes purely from the occupancy register.
  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = head_reg;
  assign out_count = out_count_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= 2'd0;
      head_reg      <= '0;
      tail_reg      <= '0;
      out_count_reg <= 16'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_reg <= ext_value;
          else                   tail_reg <= ext_value;
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          head_reg  <= tail_reg;
          count_reg <= count_reg - 2'd1;
        end
        // Push and pop together only happen with one entry (full blocks push).
        2'b11: head_reg <= ext_value;
        default: ;
      endcase
      if (pop) out_count_reg <= out_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed, table-driven bench for imm_extend_unit: extension modes, FIFO
// backpressure, async reset, throughput and a narrow-parameter instance.
module tb_imm_extend_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_count;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [11:0] s_in_data;
  logic [1:0]  s_in_mode;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [19:0] s_out_data;
  logic [15:0] s_out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_unit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  imm_extend_unit #(.IN_W(12), .OUT_W(20), .BR_SHIFT(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_count(s_out_count)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] data;
    logic [31:0] expected;
  } vec_t;

  typedef struct {
    logic [1:0]  mode;
    logic [11:0] data;
    logic [19:0] expected;
  } svec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("check %s: got 0x%0h ok", name, act);
    end
  endtask

  vec_t  vecs [10];
  svec_t svecs[4];

  initial begin
    vecs[0] = '{2'b00, 16'h01DD, 32'h000001DD};
    vecs[1] = '{2'b00, 16'hAFDE, 32'hFFFFAFDE};
    vecs[2] = '{2'b01, 16'hAFDE, 32'h0000AFDE};
    vecs[3] = '{2'b10, 16'hAFDE, 32'hAFDE0000};
    vecs[4] = '{2'b11, 16'hAFDE, 32'hFFFEBF78};
    vecs[5] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
    vecs[6] = '{2'b01, 16'h8000, 32'h00008000};
    vecs[7] = '{2'b10, 16'h0001, 32'h00010000};
    vecs[8] = '{2'b00, 16'hFFFF, 32'hFFFFFFFF};
    vecs[9] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
    svecs[0] = '{2'b00, 12'h800, 20'hFF800};
    svecs[1] = '{2'b01, 12'h800, 20'h00800};
    svecs[2] = '{2'b10, 12'h800, 20'h80000};
    svecs[3] = '{2'b11, 12'h800, 20'hFF000};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_in_mode = '0; s_out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_count", {16'd0, out_count}, 32'd0);
    rst = 1'b0;

    // Mode table: push, check one cycle later, then pop.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = vecs[i].data; in_mode = vecs[i].mode; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].expected);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end
    check("table_count", {16'd0, out_count}, 32'd10);

    // Backpressure: three pushes with out_ready low, then drain in order.
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h0123;
    @(negedge clk);
    check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    check("bp_head_after1", out_data, 32'h00000123);
    in_mode = 2'b01; in_data = 16'h8001;
    @(negedge clk);
    check("bp_ready_after2", {31'd0, in_ready}, 32'd0);
    check("bp_head_after2", out_data, 32'h00000123);
    in_mode = 2'b10; in_data = 16'h00C3;
    @(negedge clk);
    check("bp_ready_held", {31'd0, in_ready}, 32'd0);
    check("bp_head_held", out_data, 32'h00000123);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_second_head", out_data, 32'h00008001);
    check("bp_ready_reopen", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_third_head", out_data, 32'h00C30000);
    check("bp_third_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_empty", {31'd0, out_valid}, 32'd0);
    check("bp_count", {16'd0, out_count}, 32'd13);

    // Async reset between edges with two entries stored.
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'h1234;
    @(negedge clk);
    in_data = 16'h5678;
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_full", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    check("ar_out_count", {16'd0, out_count}, 32'd0);
    check("ar_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("ar_ready_after", {31'd0, in_ready}, 32'd1);

    // Throughput: one result per cycle with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_mode = 2'b00; in_data = 16'hFF00 + 16'(i); out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("tp%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("tp%0d_data", i), out_data, 32'hFFFFFF00 + 32'(i));
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check("tp_empty", {31'd0, out_valid}, 32'd0);
    check("tp_count", {16'd0, out_count}, 32'd10);

    // Narrow-parameter instance.
    for (int i = 0; i < 4; i++) begin
      s_in_valid = 1'b1; s_in_data = svecs[i].data; s_in_mode = svecs[i].mode; s_out_ready = 1'b0;
      @(negedge clk);
      s_in_valid = 1'b0;
      check($sformatf("sweep%0d_valid", i), {31'd0, s_out_valid}, 32'd1);
      check($sformatf("sweep%0d_data", i), {12'd0, s_out_data}, {12'd0, svecs[i].expected});
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
    end
    check("sweep_count", {16'd0, s_out_count}, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
